// File: rtl/sad_pkg.sv
// Shared types and constants for the SAD template-matching controller.
package sad_pkg;

  localparam int SAD_W = 10;
  localparam logic [SAD_W-1:0] THRESHOLD_DEF = 10'd500;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_DRAIN,
    S_COMPARE,
    S_DONE
  } state_t;

  // Address width helper; keeps one-entry ranges at a legal 1-bit width.
  function automatic int aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sad_if.sv
// Control, memory-read and PE signals between the SAD controller and its parent.
interface sad_if import sad_pkg::*; #(
  parameter int WIN     = 8,
  parameter int NUM_POS = 16
);
  localparam int TW = aw(WIN);
  localparam int IW = aw(WIN + NUM_POS - 1);
  localparam int PW = aw(NUM_POS);

  logic             start;
  logic             abort;
  logic [TW-1:0]    t_addr;
  logic [IW-1:0]    i_addr;
  logic             rd_en;
  logic             t_rdata;
  logic             i_rdata;
  logic             pe_in_t;
  logic             pe_in_i;
  logic             pe_select_s;
  logic             pe_clr;
  logic [SAD_W-1:0] pe_sad;
  logic             busy;
  logic             done;
  logic [SAD_W-1:0] best_sad;
  logic [PW-1:0]    best_pos;
  logic             best_sat;

  modport master (
    input  start, abort, t_rdata, i_rdata, pe_sad,
    output t_addr, i_addr, rd_en, pe_in_t, pe_in_i, pe_select_s, pe_clr,
           busy, done, best_sad, best_pos, best_sat
  );

  modport slave (
    output start, abort, t_rdata, i_rdata, pe_sad,
    input  t_addr, i_addr, rd_en, pe_in_t, pe_in_i, pe_select_s, pe_clr,
           busy, done, best_sad, best_pos, best_sat
  );

endinterface

// File: rtl/sad_best_tracker.sv
// Running-minimum register: keeps the lowest SAD and its offset, earliest offset on ties.
module sad_best_tracker import sad_pkg::*; #(
  parameter int PW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             first,
  input  logic [SAD_W-1:0] sad,
  input  logic [PW-1:0]    pos,
  output logic [SAD_W-1:0] best_sad,
  output logic [PW-1:0]    best_pos
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_sad <= '0;
      best_pos <= '0;
    end else if (load && (first || sad < best_sad)) begin
      best_sad <= sad;
      best_pos <= pos;
    end
  end

endmodule

// File: rtl/sad_controller.sv
// Sequences a bit-serial SAD search over NUM_POS image offsets and tracks the best match.
module sad_controller import sad_pkg::*; #(
  parameter int               WIN       = 8,
  parameter int               NUM_POS   = 16,
  parameter logic [SAD_W-1:0] THRESHOLD = THRESHOLD_DEF
) (
  input logic   clk,
  input logic   rst,
  sad_if.master bus
);

  localparam int TW = aw(WIN);
  localparam int IW = aw(WIN + NUM_POS - 1);
  localparam int PW = aw(NUM_POS);

  state_t           state, nstate;
  logic [TW-1:0]    k;
  logic [PW-1:0]    pos;
  logic             vld_q;
  logic             last_k, last_pos, accept;
  logic             trk_load, trk_first;
  logic [SAD_W-1:0] trk_sad;
  logic [PW-1:0]    trk_pos;

  assign last_k   = (k == TW'(WIN - 1));
  assign last_pos = (pos == PW'(NUM_POS - 1));
  assign accept   = (state == S_IDLE) && bus.start && !bus.abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE:    if (accept) nstate = S_CLEAR;
      S_CLEAR:   nstate = S_FETCH;
      S_FETCH:   if (last_k) nstate = S_DRAIN;
      S_DRAIN:   nstate = S_COMPARE;
      S_COMPARE: nstate = last_pos ? S_DONE : S_CLEAR;
      S_DONE:    nstate = S_IDLE;
      default:   nstate = S_IDLE;
    endcase
    if (state != S_IDLE && bus.abort) nstate = S_IDLE;
  end

  // k is parked at 0 outside FETCH, so it never runs past WIN-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k     <= '0;
      pos   <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= bus.rd_en;
      if (state == S_FETCH && !last_k) k <= k + TW'(1);
      else                             k <= '0;
      if (accept)
        pos <= '0;
      else if (state == S_COMPARE && !last_pos && !bus.abort)
        pos <= pos + PW'(1);
    end
  end

  assign bus.rd_en       = (state == S_FETCH);
  assign bus.t_addr      = k;
  assign bus.i_addr      = IW'(pos) + IW'(k);
  assign bus.pe_in_t     = bus.t_rdata & vld_q;
  assign bus.pe_in_i     = bus.i_rdata & vld_q;
  assign bus.pe_select_s = (state inside {S_CLEAR, S_FETCH, S_DRAIN, S_COMPARE});
  assign bus.pe_clr      = (state inside {S_IDLE, S_CLEAR, S_DONE});
  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = (state == S_DONE) && !bus.abort;
  assign bus.best_sat    = (bus.best_sad == THRESHOLD);

  // Start acceptance seeds the tracker with THRESHOLD through its forced-load path.
  assign trk_load  = accept || (state == S_COMPARE && !bus.abort);
  assign trk_first = accept || (pos == '0);
  assign trk_sad   = accept ? THRESHOLD : bus.pe_sad;
  assign trk_pos   = accept ? '0 : pos;

  sad_best_tracker #(.PW(PW)) u_best (
    .clk      (clk),
    .rst      (rst),
    .load     (trk_load),
    .first    (trk_first),
    .sad      (trk_sad),
    .pos      (trk_pos),
    .best_sad (bus.best_sad),
    .best_pos (bus.best_pos)
  );

endmodule

// File: tb/tb_sad_controller.sv
// Directed bench: bit memories and a saturating PE model around two controller configurations.
module tb_sad_controller;
  import sad_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sad_if #(.WIN(8), .NUM_POS(4)) bus ();
  sad_if #(.WIN(8), .NUM_POS(1)) bus1 ();

  sad_controller #(.WIN(8), .NUM_POS(4)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  sad_controller #(.WIN(8), .NUM_POS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [7:0]  t_vec;
  logic [10:0] i_vec;
  logic        force_sat;
  logic        t_rd = 1'b0, i_rd = 1'b0, t_rd1 = 1'b0, i_rd1 = 1'b0;
  logic [9:0]  acc = '0, acc1 = '0;
  int          n_chk = 0, n_err = 0;
  int          first, cnt, rds;

  function automatic logic [9:0] pe_next(input logic [9:0] a, input logic sel,
                                         input logic b_t, input logic b_i);
    int s;
    s = (sel ? int'(a) : 0) + ((b_t ^ b_i) ? 1 : 0);
    if (s > 500) s = 500;
    return 10'(s);
  endfunction

  always @(posedge clk) begin
    t_rd  <= t_vec[bus.t_addr];
    i_rd  <= i_vec[bus.i_addr];
    t_rd1 <= t_vec[bus1.t_addr];
    i_rd1 <= i_vec[bus1.i_addr];
    acc   <= bus.pe_clr  ? '0 : pe_next(acc,  bus.pe_select_s,  bus.pe_in_t,  bus.pe_in_i);
    acc1  <= bus1.pe_clr ? '0 : pe_next(acc1, bus1.pe_select_s, bus1.pe_in_t, bus1.pe_in_i);
  end

  assign bus.t_rdata  = t_rd;
  assign bus.i_rdata  = i_rd;
  assign bus.pe_sad   = force_sat ? 10'd500 : acc;
  assign bus1.t_rdata = t_rd1;
  assign bus1.i_rdata = i_rd1;
  assign bus1.pe_sad  = acc1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic launch();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Cycle c is sampled at the negedge just before the c-th edge after start acceptance.
  task automatic watch(input int win, input int sp, output int f, output int n, output int r);
    f = -1; n = 0; r = 0;
    for (int c = 1; c <= win; c++) begin
      @(negedge clk);
      if (bus.done) begin
        n++;
        if (f < 0) f = c;
      end
      if (bus.rd_en) r++;
      bus.start = (c == sp);
    end
    bus.start = 1'b0;
  endtask

  task automatic chk_best(input string tag, input int s, input int p, input int sat);
    chk({tag, "_sad"}, int'(bus.best_sad), s);
    chk({tag, "_pos"}, int'(bus.best_pos), p);
    chk({tag, "_sat"}, int'(bus.best_sat), sat);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},  int'(bus.busy), 0);
    chk({tag, "_done"},  int'(bus.done), 0);
    chk({tag, "_rd_en"}, int'(bus.rd_en), 0);
    chk({tag, "_clr"},   int'(bus.pe_clr), 1);
    chk({tag, "_sel"},   int'(bus.pe_select_s), 0);
    chk_best(tag, 0, 0, 0);
  endtask

  initial begin
    bus.start = 1'b0;  bus.abort = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0;
    force_sat = 1'b0;
    t_vec = 8'hF0;
    i_vec = 11'h0F0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst = 1'b0;
    @(negedge clk);

    // start together with abort in IDLE must not launch or seed the tracker
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("sa_busy", int'(bus.busy), 0);
    chk("sa_sat",  int'(bus.best_sat), 0);

    // template F0 vs image 0F0: SADs 0,2,4,6
    launch();
    watch(60, 0, first, cnt, rds);
    chk("v1_done_cyc", first, 45);
    chk("v1_done_cnt", cnt, 1);
    chk("v1_rd_cnt",   rds, 32);
    chk_best("v1", 0, 0, 0);

    // template AA vs image 555: SADs 8,0,8,0 -> tie keeps offset 1
    t_vec = 8'hAA;
    i_vec = 11'h555;
    launch();
    watch(60, 0, first, cnt, rds);
    chk("v2_done_cyc", first, 45);
    chk_best("v2", 0, 1, 0);

    force_sat = 1'b1;
    launch();
    watch(60, 0, first, cnt, rds);
    chk("v3_done_cnt", cnt, 1);
    chk_best("v3", 500, 0, 1);
    force_sat = 1'b0;

    // abort in FETCH of offset 2 (k=2); offsets 0,1 already compared
    launch();
    repeat (26) @(negedge clk);
    chk("v4_rd_en",  int'(bus.rd_en), 1);
    chk("v4_t_addr", int'(bus.t_addr), 2);
    chk("v4_i_addr", int'(bus.i_addr), 4);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("v4_busy", int'(bus.busy), 0);
    watch(60, 0, first, cnt, rds);
    chk("v4_done_cnt", cnt, 0);
    chk_best("v4", 0, 1, 0);

    // start pulsed during COMPARE of offset 0
    t_vec = 8'hF0;
    i_vec = 11'h0F0;
    launch();
    watch(60, 11, first, cnt, rds);
    chk("v5_done_cyc", first, 45);
    chk("v5_done_cnt", cnt, 1);
    chk_best("v5", 0, 0, 0);

    // asynchronous reset during DRAIN of offset 1
    t_vec = 8'hAA;
    i_vec = 11'h555;
    launch();
    repeat (20) @(posedge clk);
    #2;
    chk("v6_pre_busy",  int'(bus.busy), 1);
    chk("v6_pre_rd_en", int'(bus.rd_en), 0);
    rst = 1'b1;
    #1;
    chk_reset("v6_rst");
    @(negedge clk);
    rst = 1'b0;
    launch();
    watch(60, 0, first, cnt, rds);
    chk("v6_done_cyc", first, 45);
    chk("v6_done_cnt", cnt, 1);
    chk_best("v6", 0, 1, 0);

    // single-candidate configuration: template F0 vs image bits 55 -> SAD 4
    t_vec = 8'hF0;
    i_vec = 11'h555;
    @(negedge clk);
    bus1.start = 1'b1;
    @(posedge clk);
    #1 bus1.start = 1'b0;
    first = -1; cnt = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) chk("u1_busy", int'(bus1.busy), 1);
      if (bus1.done) begin
        cnt++;
        if (first < 0) first = c;
      end
    end
    chk("u1_done_cyc", first, 12);
    chk("u1_done_cnt", cnt, 1);
    chk("u1_sad", int'(bus1.best_sad), 4);
    chk("u1_pos", int'(bus1.best_pos), 0);
    chk("u1_sat", int'(bus1.best_sat), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
